// File: rtl/hazard_ctrl_unit.sv
// Hazard control: registered flush sequencing on PC mispredict, plus load-use stall.
// Define HAZARD_LOAD_USE_EN to build the load-use stall path and stall_cnt.
module hazard_ctrl_unit #(
   parameter int unsigned PC_W         = 12,
   parameter int unsigned WARMUP       = 5,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [PC_W-1:0]  pc_pred,
   input  logic [PC_W-1:0]  pc_actual,
   input  logic             ex_valid,
   input  logic [31:0]      num_inst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   output logic             flush,
   output logic             stall,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   localparam logic [7:0] WarmMax = 8'(WARMUP);
   localparam logic [3:0] FlInit  = 4'(FLUSH_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       fl_q, fl_d;
   logic [7:0]       warm_q, warm_d;
   logic             flush_q, flush_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [PC_W-1:0]  pc_seq;
   logic             mismatch;
   logic             armed;
   logic             detect;

   // Sequential successor wraps modulo 2^PC_W.
   assign pc_seq   = pc_pred + PC_W'(4);
   assign mismatch = ex_valid && (pc_actual != pc_seq);
   assign armed    = (warm_q == WarmMax);
   assign detect   = mismatch && armed && (num_inst != 32'd0);
   assign warm_d   = armed ? warm_q : warm_q + 8'd1;

   // Detection only in StIdle, so wrong-path mismatches never extend a flush.
   always_comb begin
      state_d     = state_q;
      fl_d        = fl_q;
      flush_cnt_d = flush_cnt_q;
      flush_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (detect) begin
               state_d     = StFlush;
               fl_d        = FlInit;
               flush_d     = 1'b1;
               flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
            end
         end
         StFlush: begin
            if (fl_q == 4'd0) begin
               state_d = StIdle;
            end else begin
               fl_d    = fl_q - 4'd1;
               flush_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q     <= StIdle;
         fl_q        <= 4'd0;
         warm_q      <= 8'd0;
         flush_q     <= 1'b0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         fl_q        <= fl_d;
         warm_q      <= warm_d;
         flush_q     <= flush_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign flush     = flush_q;
   assign flush_cnt = flush_cnt_q;

`ifdef HAZARD_LOAD_USE_EN
   logic             load_use;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   assign load_use = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   assign stall    = load_use && armed && (state_q == StIdle) && !flush_q;

   assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

   a_flush_over_stall: assert property (@(posedge clk) disable iff (rstn) !(flush_q && stall));
`else
   logic unused_load_use;
   assign unused_load_use = ^{ex_memread, ex_rd, id_rs1, id_rs2};
   assign stall           = 1'b0;
   assign stall_cnt       = '0;
`endif

   a_flush_state: assert property (@(posedge clk) disable iff (rstn)
                                    flush_q == (state_q == StFlush));

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized + directed bench for hazard_ctrl_unit against an event-based reference model.
module tb_hazard_ctrl_unit;

   localparam int PC_W         = 12;
   localparam int WARMUP       = 5;
   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 4;
   localparam int PC_MASK      = (1 << PC_W) - 1;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;
`ifdef HAZARD_LOAD_USE_EN
   localparam bit LU_EN = 1'b1;
`else
   localparam bit LU_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rstn = 1'b1;
   logic [PC_W-1:0]  pc_pred = '0;
   logic [PC_W-1:0]  pc_actual = '0;
   logic             ex_valid = 1'b0;
   logic [31:0]      num_inst = '0;
   logic [4:0]       id_rs1 = '0;
   logic [4:0]       id_rs2 = '0;
   logic [4:0]       ex_rd = '0;
   logic             ex_memread = 1'b0;
   logic             flush;
   logic             stall;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] stall_cnt;

   int tests = 0;
   int fails = 0;

   hazard_ctrl_unit #(
      .PC_W        (PC_W),
      .WARMUP      (WARMUP),
      .FLUSH_CYCLES(FLUSH_CYCLES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .pc_pred   (pc_pred),
      .pc_actual (pc_actual),
      .ex_valid  (ex_valid),
      .num_inst  (num_inst),
      .id_rs1    (id_rs1),
      .id_rs2    (id_rs2),
      .ex_rd     (ex_rd),
      .ex_memread(ex_memread),
      .flush     (flush),
      .stall     (stall),
      .flush_cnt (flush_cnt),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: cycles since reset, cycle of the last accepted mispredict, and event totals.
   int m_cyc = 0;
   int m_last_det = -100;
   int m_fcnt = 0;
   int m_scnt = 0;

   function automatic bit m_flush();
      return ((m_cyc - m_last_det) >= 1) && ((m_cyc - m_last_det) <= FLUSH_CYCLES);
   endfunction

   function automatic bit m_armed();
      return m_cyc >= WARMUP;
   endfunction

   function automatic bit m_stall();
      bit lu;
      lu = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
      return LU_EN && lu && m_armed() && !m_flush();
   endfunction

   always @(posedge clk or posedge rstn) begin
      if (rstn) begin
         m_cyc      = 0;
         m_last_det = -100;
         m_fcnt     = 0;
         m_scnt     = 0;
      end else begin
         bit mis;
         mis = ex_valid && (int'(pc_actual) != ((int'(pc_pred) + 4) & PC_MASK));
         if (m_stall() && m_scnt < CNT_MAX) m_scnt++;
         if (mis && m_armed() && num_inst != 32'd0 && !m_flush()) begin
            m_last_det = m_cyc;
            if (m_fcnt < CNT_MAX) m_fcnt++;
         end
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (!rstn) begin
         chk("model_flush", 32'(flush), 32'(m_flush()));
         chk("model_stall", 32'(stall), 32'(m_stall()));
         chk("model_flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
         chk("model_stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   bit exp35 [0:9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
   bit exp37 [0:4] = '{1, 1, 0, 1, 1};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      // Mispredict held from the first post-reset cycle.
      pc_pred  = 12'h010;
      pc_actual = 12'h040;
      ex_valid = 1'b1;
      num_inst = 32'd1;
      rstn     = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #2;
         chk("warmup_flush", 32'(flush), 32'(exp35[c]));
         if (c == 8) begin
            chk("flush_cnt_first", 32'(flush_cnt), 32'd1);
            ex_valid = 1'b0;
         end
         tick();
      end

      // PC wrap-around is sequential, off-by-four is not.
      num_inst  = 32'd3;
      pc_pred   = 12'hFFC;
      pc_actual = 12'h000;
      ex_valid  = 1'b1;
      tick();
      #2 chk("wrap_no_flush", 32'(flush), 32'd0);
      pc_actual = 12'h004;
      tick();
      #2 chk("wrap_flush_1", 32'(flush), 32'd1);
      ex_valid = 1'b0;
      tick();
      #2 chk("wrap_flush_2", 32'(flush), 32'd1);
      tick();
      #2 chk("wrap_flush_end", 32'(flush), 32'd0);
      chk("flush_cnt_two", 32'(flush_cnt), 32'd2);

      // Mispredict held four cycles: wrong-path mismatches ignored.
      pc_pred   = 12'h100;
      pc_actual = 12'h200;
      ex_valid  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (c == 3) ex_valid = 1'b0;
         #2 chk("held_pattern", 32'(flush), 32'(exp37[c]));
      end
      chk("flush_cnt_four", 32'(flush_cnt), 32'd4);

      // Reset during the second flush cycle.
      tick();
      #2 chk("idle_before_rst", 32'(flush), 32'd0);
      ex_valid = 1'b1;
      tick();
      ex_valid = 1'b0;
      tick();
      chk("second_flush", 32'(flush), 32'd1);
      #1 rstn = 1'b1;
      #1;
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(posedge clk);
      #1;
      rstn     = 1'b0;
      ex_valid = 1'b1;
      for (int c = 0; c <= WARMUP; c++) begin
         #2 chk("post_rst_quiet", 32'(flush), 32'd0);
         tick();
      end
      #2 chk("rearm_flush", 32'(flush), 32'd1);
      ex_valid = 1'b0;
      repeat (3) tick();

      // Load-use stall, rd=0 exemption, flush priority.
      ex_memread = 1'b1;
      ex_rd      = 5'd5;
      id_rs2     = 5'd5;
      id_rs1     = 5'd7;
      #1 chk("lu_stall", 32'(stall), 32'(LU_EN));
      ex_rd = 5'd0;
      #1 chk("lu_rd0", 32'(stall), 32'd0);
      ex_rd    = 5'd5;
      ex_valid = 1'b1;
      tick();
      #2;
      chk("lu_flush_on", 32'(flush), 32'd1);
      chk("stall_vs_flush", 32'(stall), 32'd0);
      chk("stall_cnt_one", 32'(stall_cnt), 32'(LU_EN));
      ex_valid = 1'b0;
      tick();
      tick();
      #2 chk("stall_resume", 32'(stall), 32'(LU_EN));
      ex_memread = 1'b0;
      tick();

      // Random traffic with occasional resets; narrow counters reach saturation.
      for (int i = 0; i < 4000; i++) begin
         pc_pred    = PC_W'($urandom);
         pc_actual  = ($urandom_range(0, 3) == 0) ? PC_W'($urandom) : pc_pred + PC_W'(4);
         ex_valid   = ($urandom_range(0, 3) != 0);
         num_inst   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         ex_memread = 1'($urandom);
         ex_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
         id_rs1     = 5'($urandom_range(0, 7));
         id_rs2     = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 499) == 0) begin
            rstn = 1'b1;
            tick();
            tick();
            rstn = 1'b0;
         end
         tick();
      end
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter PC_W, default 12, meaning PC width in bits.
REQ-002 SHALL have parameter WARMUP, default 5, meaning the number of post-reset cycles during which hazard detection is suppressed (range 0..255).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, meaning the flush pulse length in cycles (range 1..15).
REQ-004 SHALL have parameter CNT_W, default 16, meaning the event counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: the asynchronous, active-high reset (asserted = 1).
REQ-007 SHALL have port pc_pred, input, PC_W bits: the PC of the instruction currently in EX.
REQ-008 SHALL have port pc_actual, input, PC_W bits: the resolved next PC from EX.
REQ-009 SHALL have port ex_valid, input, 1 bit: EX holds a real (non-bubble) instruction.
REQ-010 SHALL have port num_inst, input, 32 bits: the retired-instruction count.
REQ-011 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: the ID-stage source registers.
REQ-012 SHALL have port ex_rd, input, 5 bits: the EX-stage destination register.
REQ-013 SHALL have port ex_memread, input, 1 bit: the EX instruction is a load.
REQ-014 SHALL have port flush, output, 1 bit: squash IF/ID and ID/EX.
REQ-015 SHALL have port stall, output, 1 bit: hold PC and IF/ID, bubble ID/EX.
REQ-016 SHALL have port flush_cnt, output, CNT_W bits: the number of flush events.
REQ-017 SHALL have port stall_cnt, output, CNT_W bits: the number of stall cycles.

Function
REQ-018 SHALL define mismatch = ex_valid AND (pc_actual != pc_pred + 4), with the addition taken modulo 2^PC_W.
REQ-019 SHALL keep warm counter warm_q, 8 bits, incrementing each cycle and saturating at WARMUP (no wrap); armed = (warm_q == WARMUP).
REQ-020 SHALL implement FSM states IDLE and FLUSH, with a 4-bit down-counter fl_q.
REQ-021 In IDLE, when mismatch AND armed AND num_inst > 0, SHALL enter FLUSH with fl_q = FLUSH_CYCLES-1 and increment flush_cnt.
REQ-022 flush SHALL be registered: high exactly FLUSH_CYCLES consecutive cycles, beginning the cycle after detection.
REQ-023 In FLUSH, fl_q SHALL decrement each cycle; when fl_q = 0, return to IDLE.
REQ-024 A mismatch during FLUSH SHALL be ignored (wrong-path) and SHALL NOT extend or restart the flush.
REQ-025 A mismatch on the same edge FLUSH returns to IDLE SHALL be ignored; detection resumes the following cycle.
REQ-026 stall SHALL be combinational: stall = load-use AND state==IDLE AND NOT flush, where load-use = ex_memread AND ex_rd != 0 AND (ex_rd == id_rs1 OR ex_rd == id_rs2).
REQ-027 flush SHALL take priority over stall; both SHALL never be high in the same cycle.
REQ-028 stall_cnt SHALL increment on every cycle with stall high.
REQ-029 Both counters SHALL saturate at all-ones and never wrap.
REQ-030 stall SHALL be suppressed while not armed.

Reset
REQ-031 rstn high SHALL immediately and asynchronously force state = IDLE, fl_q = 0, warm_q = 0, flush = 0, flush_cnt = 0 and stall_cnt = 0.
REQ-032 Reset asserted mid-FLUSH SHALL drop flush in the same cycle; on deassertion, warm-up SHALL restart from 0.

Configuration
REQ-033 Macro HAZARD_LOAD_USE_EN defined: load-use stall logic and stall_cnt SHALL be as in REQ-026..REQ-030.
REQ-034 Macro HAZARD_LOAD_USE_EN undefined: stall SHALL be tied to 0 and stall_cnt tied to 0; control-hazard behaviour SHALL be unchanged.

Verification
REQ-035 Reset, then pc_pred=0x010, pc_actual=0x040, ex_valid=1 held from cycle 1 -> flush stays 0 through cycle 5; flush is high cycles 7-8 (FLUSH_CYCLES=2); flush_cnt=1.
REQ-036 Armed, num_inst=3, pc_pred=0xFFC, pc_actual=0x000 -> no flush (wrap-around sequential); pc_actual=0x004 -> flush for 2 cycles.
REQ-037 Armed, mismatch held 4 cycles with FLUSH_CYCLES=2 -> flush pattern 1,1,0,1,1; flush_cnt=2.
REQ-038 Armed, ex_memread=1, ex_rd=5, id_rs2=5 -> stall=1 the same cycle; with ex_rd=0 -> stall=0; with a simultaneous flush -> stall=0.
REQ-039 rstn pulsed high during the second flush cycle -> flush=0 immediately, counters=0, next mismatch ignored for WARMUP cycles.
REQ-040 Build without HAZARD_LOAD_USE_EN, then apply the REQ-038 stimulus -> stall=0 and stall_cnt=0 throughout.
